// File: rtl/pixel_loader.sv
// pixel_loader: accepts one RGB_SIZE-bit pixel frame from the byte stream after a start
// strobe and writes it row-major into the frame SRAM with (x, y) tracking.
// When INGEST_CHECKSUM_EN is defined, a 16-bit additive checksum of the frame is kept.
// When it is undefined, checksum is tied to zero.
module pixel_loader #(
  parameter int unsigned IMAGEX           = 16,
  parameter int unsigned IMAGEY           = 16,
  parameter int unsigned IMAGE_SIZE       = IMAGEX * IMAGEY,
  parameter int unsigned IMAGEXlog2       = $clog2(IMAGEX),
  parameter int unsigned IMAGEYlog2       = $clog2(IMAGEY),
  parameter int unsigned IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE),
  parameter int unsigned RGB_SIZE         = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        dither_busy,
  input  logic [RGB_SIZE-1:0]         pixel_in,
  input  logic                        pixel_valid,
  output logic                        ready,
  output logic                        busy,
  output logic                        sram_we,
  output logic [IMAGE_ADDR_WIDTH-1:0] sram_addr,
  output logic [RGB_SIZE-1:0]         sram_wdata,
  output logic [IMAGEXlog2-1:0]       x,
  output logic [IMAGEYlog2-1:0]       y,
  output logic                        load_done,
  output logic [15:0]                 checksum
);

  localparam int unsigned CNT_W = IMAGE_ADDR_WIDTH + 1;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [IMAGEXlog2-1:0]       col_q, col_d;
  logic [IMAGEYlog2-1:0]       row_q, row_d;
  logic                        ready_q, ready_d;
  logic                        busy_q, busy_d;
  logic                        sram_we_q, sram_we_d;
  logic [IMAGE_ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
  logic [RGB_SIZE-1:0]         sram_wdata_q, sram_wdata_d;
  logic [IMAGEXlog2-1:0]       x_q, x_d;
  logic [IMAGEYlog2-1:0]       y_q, y_d;
  logic                        load_done_q, load_done_d;
`ifdef INGEST_CHECKSUM_EN
  logic [15:0]                 checksum_q, checksum_d;
`endif

  // Next-state, write-path and coordinate logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    col_d        = col_q;
    row_d        = row_q;
    sram_we_d    = 1'b0;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    x_d          = x_q;
    y_d          = y_q;
    load_done_d  = 1'b0;
`ifdef INGEST_CHECKSUM_EN
    checksum_d   = checksum_q;
`endif

    case (state_q)
      IDLE: begin
        if (start && !dither_busy) begin
          state_d = LOAD;
          cnt_d   = '0;
          col_d   = '0;
          row_d   = '0;
          x_d     = '0;
          y_d     = '0;
`ifdef INGEST_CHECKSUM_EN
          checksum_d = '0;
`endif
        end
      end
      LOAD: begin
        if (pixel_valid) begin
          sram_we_d    = 1'b1;
          sram_addr_d  = cnt_q[IMAGE_ADDR_WIDTH-1:0];
          sram_wdata_d = pixel_in;
          x_d          = col_q;
          y_d          = row_q;
          cnt_d        = cnt_q + CNT_W'(1);
`ifdef INGEST_CHECKSUM_EN
          checksum_d   = checksum_q + 16'(pixel_in);
`endif
          if (cnt_q == CNT_W'(IMAGE_SIZE - 1)) begin
            // Final pixel: finish the frame; the position counters are not advanced.
            state_d     = IDLE;
            load_done_d = 1'b1;
          end else if (col_q == IMAGEXlog2'(IMAGEX - 1)) begin
            col_d = '0;
            row_d = row_q + IMAGEYlog2'(1);
          end else begin
            col_d = col_q + IMAGEXlog2'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == LOAD);
    busy_d  = (state_d == LOAD);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      col_q        <= '0;
      row_q        <= '0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      x_q          <= '0;
      y_q          <= '0;
      load_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      col_q        <= col_d;
      row_q        <= row_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      x_q          <= x_d;
      y_q          <= y_d;
      load_done_q  <= load_done_d;
    end
  end

`ifdef INGEST_CHECKSUM_EN
  // Frame checksum register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) checksum_q <= '0;
    else          checksum_q <= checksum_d;
  end
  assign checksum = checksum_q;
`else
  assign checksum = 16'h0000;
`endif

  assign ready      = ready_q;
  assign busy       = busy_q;
  assign sram_we    = sram_we_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;
  assign x          = x_q;
  assign y          = y_q;
  assign load_done  = load_done_q;

endmodule

// File: tb/tb_pixel_loader.sv
// Testbench for pixel_loader.
// It applies a table of control vectors and several frame sequences.
// A scoreboard checks every SRAM write.
module tb_pixel_loader;

  localparam int unsigned IMAGEX = 16;
  localparam int unsigned IMAGEY = 16;
  localparam int unsigned NPIX   = IMAGEX * IMAGEY;
`ifdef INGEST_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       dither_busy;
  logic [7:0] pixel_in;
  logic       pixel_valid;
  logic       ready, busy, sram_we, load_done;
  logic [7:0] sram_addr, sram_wdata;
  logic [3:0] x, y;
  logic [15:0] checksum;

  pixel_loader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .dither_busy(dither_busy),
    .pixel_in(pixel_in), .pixel_valid(pixel_valid), .ready(ready), .busy(busy),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .x(x), .y(y), .load_done(load_done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [3:0]  xx;
    logic [3:0]  yy;
    logic        last;
    logic [15:0] sum;
  } exp_t;

  typedef struct {
    logic       start;
    logic       db;
    logic       pv;
    logic [7:0] pix;
    logic       exp_ready;
    logic       exp_we;
  } vec_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_idx  = 0;
  logic [15:0] exp_sum  = '0;
  int          done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Advance one clock edge; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Record the write expected from a pixel that the loader will accept.
  task automatic push_pixel(input logic [7:0] d);
    exp_t e;
    e.addr = 8'(exp_idx);
    e.data = d;
    e.xx   = 4'(exp_idx % IMAGEX);
    e.yy   = 4'(exp_idx / IMAGEX);
    e.last = (exp_idx == NPIX - 1);
    exp_sum = exp_sum + 16'(d);
    e.sum  = CSUM_ON ? exp_sum : 16'h0000;
    sb.push_back(e);
    exp_idx++;
  endtask

  task automatic new_frame();
    exp_idx = 0;
    exp_sum = '0;
  endtask

  // Drive one accepted pixel, followed by `gap` idle cycles.
  task automatic send_pixel(input logic [7:0] d, input int gap);
    pixel_valid = 1'b1;
    pixel_in    = d;
    push_pixel(d);
    tick();
    pixel_valid = 1'b0;
    for (int g = 0; g < gap; g++) tick();
  endtask

  // Compare each SRAM write with the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (load_done === 1'b1) begin
        done_cnt++;
        check("load_done_with_we", 32'(sram_we), 32'd1);
      end
      if (sram_we === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_write_addr", 32'(sram_addr), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("wr_addr", 32'(sram_addr), 32'(e.addr));
          check("wr_data", 32'(sram_wdata), 32'(e.data));
          check("wr_x", 32'(x), 32'(e.xx));
          check("wr_y", 32'(y), 32'(e.yy));
          check("wr_load_done", 32'(load_done), 32'(e.last));
          check("wr_checksum", 32'(checksum), 32'(e.sum));
        end
      end
    end
  end

  // Bound on total simulation time.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    logic [7:0] d;

    vecs[0] = '{start:1'b0, db:1'b0, pv:1'b1, pix:8'hAA, exp_ready:1'b0, exp_we:1'b0};
    vecs[1] = '{start:1'b1, db:1'b1, pv:1'b0, pix:8'h00, exp_ready:1'b0, exp_we:1'b0};
    vecs[2] = '{start:1'b1, db:1'b1, pv:1'b1, pix:8'h11, exp_ready:1'b0, exp_we:1'b0};
    vecs[3] = '{start:1'b0, db:1'b1, pv:1'b1, pix:8'h22, exp_ready:1'b0, exp_we:1'b0};
    vecs[4] = '{start:1'b1, db:1'b0, pv:1'b0, pix:8'h00, exp_ready:1'b1, exp_we:1'b0};
    vecs[5] = '{start:1'b0, db:1'b0, pv:1'b1, pix:8'h00, exp_ready:1'b1, exp_we:1'b1};

    reset_n = 1'b0; start = 1'b0; dither_busy = 1'b0; pixel_in = '0; pixel_valid = 1'b0;
    tick(); tick();
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_we", 32'(sram_we), 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);
    reset_n = 1'b1;
    tick();

    // Frame 1: table vectors, including ignored starts while the dither core is busy.
    new_frame();
    foreach (vecs[i]) begin
      start = vecs[i].start; dither_busy = vecs[i].db;
      pixel_valid = vecs[i].pv; pixel_in = vecs[i].pix;
      if (vecs[i].exp_we) push_pixel(vecs[i].pix);
      tick();
      check($sformatf("vec%0d_ready", i), 32'(ready), 32'(vecs[i].exp_ready));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_ready));
      check($sformatf("vec%0d_we", i), 32'(sram_we), 32'(vecs[i].exp_we));
    end
    start = 1'b0; pixel_valid = 1'b0;
    // Finish the frame back-to-back; a start at pixel 100 must not restart it.
    for (int i = 1; i < NPIX; i++) begin
      start = (i == 100);
      send_pixel(8'(i), 0);
      start = 1'b0;
    end
    check("f1_done", 32'(load_done), 32'd1);
    check("f1_ready_low", 32'(ready), 32'd0);
    check("f1_busy_low", 32'(busy), 32'd0);
    check("f1_checksum", 32'(checksum), CSUM_ON ? 32'h7F80 : 32'h0);
    tick();
    check("f1_done_low", 32'(load_done), 32'd0);
    // pixel_valid pulses in IDLE must be dropped.
    for (int i = 0; i < 3; i++) begin
      pixel_valid = 1'b1; pixel_in = 8'hEE; tick();
      pixel_valid = 1'b0; tick();
    end
    check("f1_idle_ready", 32'(ready), 32'd0);
    check("f1_checksum_hold", 32'(checksum), CSUM_ON ? 32'h7F80 : 32'h0);

    // Frame 2: pixel_valid every other cycle, with a start in the load_done cycle.
    new_frame();
    start = 1'b1; tick(); start = 1'b0;
    check("f2_ready", 32'(ready), 32'd1);
    for (int i = 0; i < NPIX; i++) send_pixel(8'(i) ^ 8'h5A, (i == NPIX - 1) ? 0 : 1);
    check("f2_done", 32'(load_done), 32'd1);
    check("f2_checksum", 32'(checksum), CSUM_ON ? 32'(exp_sum) : 32'h0);
    new_frame();
    start = 1'b1; pixel_valid = 1'b1; pixel_in = 8'h77;
    tick();
    start = 1'b0; pixel_valid = 1'b0;
    check("f3_ready_after_done_start", 32'(ready), 32'd1);
    check("f3_no_write_in_done_cycle", 32'(sram_we), 32'd0);

    // Frame 3: abandon the frame with a reset after 50 pixels.
    for (int i = 0; i < 50; i++) begin
      d = 8'($urandom_range(0, 255));
      send_pixel(d, 0);
    end
    @(negedge clk); #1;
    check("f3_sb_drained", 32'(sb.size()), 32'd0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(ready), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_we", 32'(sram_we), 32'd0);
    check("mid_rst_addr", 32'(sram_addr), 32'd0);
    check("mid_rst_data", 32'(sram_wdata), 32'd0);
    check("mid_rst_xy", 32'({x, y}), 32'd0);
    check("mid_rst_checksum", 32'(checksum), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Frame 4: full random frame; addresses restart at 0.
    new_frame();
    start = 1'b1; tick(); start = 1'b0;
    check("f4_ready", 32'(ready), 32'd1);
    for (int i = 0; i < NPIX; i++) begin
      d = 8'($urandom_range(0, 255));
      send_pixel(d, 0);
    end
    check("f4_done", 32'(load_done), 32'd1);
    check("f4_checksum", 32'(checksum), CSUM_ON ? 32'(exp_sum) : 32'h0);
    tick(); tick();

    check("sb_empty", 32'(sb.size()), 32'd0);
    check("done_pulses", 32'(done_cnt), 32'd3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_loader.md
# pixel_loader

Ingest stage that sits directly upstream of the Floyd-Steinberg dithering core. On an MCU start strobe it accepts exactly one image of RGB_SIZE-bit pixels from the external byte stream. Each pixel is written into the frame SRAM in row-major order, and the loader tracks the (x, y) position of every write. When the last pixel lands it pulses a completion strobe that launches the dither core. While a load is in progress it refuses new start requests.

## Interface
Parameters:
- IMAGEX, 16, image width in pixels
- IMAGEY, 16, image height in pixels
- IMAGE_SIZE, IMAGEX*IMAGEY, pixels per frame
- IMAGEXlog2, $clog2(IMAGEX), x coordinate width
- IMAGEYlog2, $clog2(IMAGEY), y coordinate width
- IMAGE_ADDR_WIDTH, $clog2(IMAGE_SIZE), SRAM address width
- RGB_SIZE, 8, pixel width

Ports:
- clk  in  1  system clock; every output is registered on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  MCU transmit-ready strobe (MCU_TX_RDY); starts one frame load
- dither_busy  in  1  high while the downstream dither core owns the SRAM
- pixel_in  in  RGB_SIZE  external SPI pixel byte
- pixel_valid  in  1  pixel_in is valid this cycle
- ready  out  1  loader accepts pixels (drives MCU_RX_RDY)
- busy  out  1  high while the loader is in LOAD
- sram_we  out  1  SRAM write strobe
- sram_addr  out  IMAGE_ADDR_WIDTH  SRAM write address
- sram_wdata  out  RGB_SIZE  SRAM write data
- x  out  IMAGEXlog2  column of the current write
- y  out  IMAGEYlog2  row of the current write
- load_done  out  1  one-cycle pulse issued on the final write
- checksum  out  16  additive frame checksum (see Configuration)

## Operation
- States:
  - IDLE
  - LOAD
- Internal pixel counter cnt, IMAGE_ADDR_WIDTH+1 bits.
- IDLE:
  - ready=0, busy=0.
  - pixel_valid is ignored and nothing is written.
  - start=1 with dither_busy=0 moves the FSM to LOAD and clears cnt, x, y and checksum.
  - start=1 with dither_busy=1 is ignored; start is not latched for later.
- LOAD:
  - ready=1, busy=1.
  - Each cycle with pixel_valid=1 accepts pixel_in:
    - sram_addr=cnt[IMAGE_ADDR_WIDTH-1:0]
    - sram_wdata=pixel_in
    - x and y take the coordinates of this pixel
    - cnt increments
  - Coordinates follow row-major order. x increments on each pixel; when x reaches IMAGEX-1 it wraps to 0 and y increments. After the final pixel, y stays at IMAGEY-1.
  - start is ignored in LOAD; it neither restarts nor aborts the load.
  - dither_busy is ignored in LOAD.
- Final pixel: the pixel accepted when cnt==IMAGE_SIZE-1 ends the load.
  - The FSM returns to IDLE.
  - load_done pulses in the same cycle as that final write.
  - Any pixel_valid that arrives after this is dropped.
- Arithmetic: sram_addr equals {y,x} when IMAGEX is a power of two; cnt never exceeds IMAGE_SIZE.
- Reset mid-load: the FSM goes to IDLE, all outputs clear, and the partial frame is abandoned. The SRAM contents are not cleared.

## Timing
- Reset values:
  - ready=0, busy=0, sram_we=0
  - sram_addr=0, sram_wdata=0, x=0, y=0
  - load_done=0, checksum=0
- start sampled at cycle N: ready=1 and busy=1 at N+1. The first pixel can be accepted at N+1.
- pixel_valid sampled at cycle M: sram_we=1 with the matching address, data, x and y at M+1. Latency is 1 cycle.
- sram_we is high for exactly one cycle per accepted pixel. Address, data, x and y hold their values between writes.
- Throughput is one pixel per cycle, with no bubbles required.
- Final pixel sampled at M: at M+1, sram_we=1 and load_done=1 together, and ready=0 and busy=0.
  - load_done is low at M+2.
  - A start at M+1 is honoured, with the transition to LOAD at M+2.
- A full back-to-back frame takes IMAGE_SIZE+1 cycles from start to load_done.

## Configuration
- INGEST_CHECKSUM_EN defined:
  - checksum is the 16-bit sum, mod 2^16, of the zero-extended pixel_in values accepted in the current frame.
  - It is cleared when start is accepted and updated on the same cycle as the matching sram_we.
  - It is valid and stable from the load_done cycle until the next accepted start.
- INGEST_CHECKSUM_EN undefined: checksum is tied to 16'h0000 and the adder logic is removed. The port list is unchanged.

## Test plan
- Reset, then start with dither_busy=0, then 256 consecutive pixels with values 0x00..0xFF -> writes to addresses 0x00..0xFF with data equal to address. The write at address 0x0F has x=15, y=0; the write at 0x10 has x=0, y=1. load_done pulses exactly once, together with the 0xFF write. With INGEST_CHECKSUM_EN defined, checksum=0x7F80.
- Start with dither_busy=1 -> ready stays 0 and no writes occur. Then start with dither_busy=0 -> ready=1 on the next cycle.
- Start, 100 pixels, a second start pulse, then 156 more pixels -> no restart. Addresses continue 0x64..0xFF and load_done fires after 256 writes in total.
- Full frame with pixel_valid asserted every other cycle, plus pixel_valid pulses in IDLE both before start and after load_done -> exactly 256 writes, no writes in IDLE, and addresses strictly sequential.
- Assert reset_n low after 50 pixels -> all outputs are 0 within the same cycle. A new start then loads from address 0.
- Start asserted in the load_done cycle -> ready=1 on the next cycle and the second frame writes from address 0.
